// File: rtl/zx_mem_pager.sv
// zx_mem_pager: 128K Spectrum memory mapper and external SRAM cycle sequencer.
// Build option: define ZX_PAGE_READBACK_EN to return the page register on IN from the 0x7FFD decode.
module zx_mem_pager #(
  parameter int unsigned NUM_RAM_PAGES = 8,
  parameter int unsigned ROM_PAGES     = 2,
  parameter int unsigned SRAM_AW       = 18,
  parameter int unsigned WAIT_STATES   = 1
) (
  input  logic               clk_mem,
  input  logic               reset,
  input  logic [15:0]        A,
  input  logic [7:0]         D_in,
  input  logic               nMREQ,
  input  logic               nIORQ,
  input  logic               nRD,
  input  logic               nWR,
  output logic [7:0]         D_out,
  output logic               d_oe,
  output logic               nWAIT,
  output logic [21:0]        FL_ADDR,
  input  logic [7:0]         FL_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic [15:0]        SRAM_DQ_O,
  input  logic [15:0]        SRAM_DQ_I,
  output logic               SRAM_DQ_OE,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               screen_sel,
  output logic               page_lock
);
  localparam int unsigned PAGE_BITS = $clog2(NUM_RAM_PAGES);
  localparam int unsigned CNT_W     = 3;
  localparam logic [CNT_W-1:0] WS   = CNT_W'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_HOLD = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         page_q, page_d;
  logic               io_done_q, io_done_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_o_q, dq_o_d;
  logic               dq_oe_q, dq_oe_d;
  logic               we_n_q, we_n_d;
  logic               oe_n_q, oe_n_d;
  logic               nwait_q, nwait_d;
  logic               d_oe_q, d_oe_d;
  logic [7:0]         dout_q, dout_d;
  logic               flash_q, flash_d;

  logic               mem_rd_c, mem_wr_c, flash_c, io_sel_c, io_wr_c, rb_c, rom_bit_c;
  logic [4:0]         bank_c;
  logic [SRAM_AW-1:0] sram_addr_c;
  logic               unused_dq_hi;

  assign mem_rd_c  = !nMREQ && !nRD;
  assign mem_wr_c  = !nMREQ && !nWR;
  assign flash_c   = (A[15:14] == 2'b00);
  assign io_sel_c  = !nIORQ && !A[15] && !A[1];
  assign io_wr_c   = io_sel_c && !nWR;
  assign rom_bit_c = (ROM_PAGES > 1) ? page_q[4] : 1'b0;
  assign unused_dq_hi = ^SRAM_DQ_I[15:8];

`ifdef ZX_PAGE_READBACK_EN
  assign rb_c = io_sel_c && !nRD;
`else
  assign rb_c = 1'b0;
`endif

  // Select the 16K RAM bank for the current CPU address
  always_comb begin
    bank_c = 5'd0;
    case (A[15:14])
      2'b01:   bank_c = 5'd5;
      2'b10:   bank_c = 5'd2;
      2'b11:   bank_c = {2'b00, page_q[2:0]};
      default: bank_c = 5'd0;
    endcase
  end

  assign sram_addr_c = SRAM_AW'({bank_c[PAGE_BITS-1:0], A[13:0]});

  // Next-state logic: page register capture and SRAM access sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    page_d    = page_q;
    io_done_d = io_done_q;
    addr_d    = addr_q;
    dq_o_d    = dq_o_q;
    dq_oe_d   = dq_oe_q;
    we_n_d    = we_n_q;
    oe_n_d    = oe_n_q;
    nwait_d   = nwait_q;
    d_oe_d    = d_oe_q;
    dout_d    = dout_q;
    flash_d   = flash_q;

    // One capture per IO strobe; a locked register ignores writes until reset
    if (nIORQ) begin
      io_done_d = 1'b0;
    end else if (io_wr_c && !io_done_q) begin
      io_done_d = 1'b1;
      if (!page_q[5]) page_d = D_in[5:0];
    end

    case (state_q)
      S_IDLE: begin
        if (mem_rd_c || mem_wr_c) begin
          if (flash_c) begin
            state_d = S_HOLD;
            flash_d = mem_rd_c;
            d_oe_d  = mem_rd_c;
          end else begin
            state_d = S_ACC;
            addr_d  = sram_addr_c;
            cnt_d   = WS;
            nwait_d = (WS == '0);
            if (mem_wr_c) begin
              dq_o_d  = {8'h00, D_in};
              dq_oe_d = 1'b1;
              we_n_d  = 1'b0;
              oe_n_d  = 1'b1;
            end
          end
        end
      end
      S_ACC: begin
        if (nMREQ) begin
          // CPU abandoned the access: release the bus immediately
          state_d = S_IDLE;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b0;
          nwait_d = 1'b1;
          d_oe_d  = 1'b0;
          dq_oe_d = 1'b0;
        end else if (cnt_q == '0) begin
          if (!dq_oe_q) begin
            dout_d = SRAM_DQ_I[7:0];
            d_oe_d = 1'b1;
          end
          we_n_d  = 1'b1;
          oe_n_d  = 1'b0;
          nwait_d = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          nwait_d = (cnt_q == CNT_W'(1));
        end
      end
      S_HOLD: begin
        if (nMREQ) begin
          state_d = S_IDLE;
          dq_oe_d = 1'b0;
          d_oe_d  = 1'b0;
          flash_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_mem) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      page_q    <= '0;
      io_done_q <= 1'b0;
      addr_q    <= '0;
      dq_o_q    <= '0;
      dq_oe_q   <= 1'b0;
      we_n_q    <= 1'b1;
      oe_n_q    <= 1'b0;
      nwait_q   <= 1'b1;
      d_oe_q    <= 1'b0;
      dout_q    <= '0;
      flash_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      page_q    <= page_d;
      io_done_q <= io_done_d;
      addr_q    <= addr_d;
      dq_o_q    <= dq_o_d;
      dq_oe_q   <= dq_oe_d;
      we_n_q    <= we_n_d;
      oe_n_q    <= oe_n_d;
      nwait_q   <= nwait_d;
      d_oe_q    <= d_oe_d;
      dout_q    <= dout_d;
      flash_q   <= flash_d;
    end
  end

  assign FL_ADDR    = 22'({rom_bit_c, A[13:0]});
  assign D_out      = flash_q ? FL_DQ : (rb_c ? {2'b00, page_q} : dout_q);
  assign d_oe       = d_oe_q || rb_c;
  assign nWAIT      = nwait_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_DQ_O  = dq_o_q;
  assign SRAM_DQ_OE = dq_oe_q;
  assign SRAM_WE_N  = we_n_q;
  assign SRAM_OE_N  = oe_n_q;
  assign screen_sel = page_q[3];
  assign page_lock  = page_q[5];

endmodule

// File: tb/tb_zx_mem_pager.sv
// tb_zx_mem_pager: randomized bench for zx_mem_pager with flash/SRAM device models and a memory-map reference.
module tb_zx_mem_pager;
  localparam int NRP = 8;
  localparam int RP  = 2;
  localparam int AW  = 18;
  localparam int WS  = 3;

  logic          clk_mem = 1'b0;
  logic          reset;
  logic [15:0]   A;
  logic [7:0]    D_in;
  logic          nMREQ, nIORQ, nRD, nWR;
  logic [7:0]    D_out;
  logic          d_oe, nWAIT;
  logic [21:0]   FL_ADDR;
  logic [7:0]    FL_DQ;
  logic [AW-1:0] SRAM_ADDR;
  logic [15:0]   SRAM_DQ_O, SRAM_DQ_I;
  logic          SRAM_DQ_OE, SRAM_WE_N, SRAM_OE_N, screen_sel, page_lock;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic          fl_force;
  logic [7:0]    fl_force_val;
  logic [7:0]    sram [0:(1<<AW)-1];
  logic [5:0]    ref_page;
  logic [7:0]    ref_mem [int];
  logic [15:0]   wq [$];

  always #5 clk_mem = ~clk_mem;

  zx_mem_pager #(.NUM_RAM_PAGES(NRP), .ROM_PAGES(RP), .SRAM_AW(AW), .WAIT_STATES(WS)) dut (
    .clk_mem(clk_mem), .reset(reset), .A(A), .D_in(D_in),
    .nMREQ(nMREQ), .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR),
    .D_out(D_out), .d_oe(d_oe), .nWAIT(nWAIT),
    .FL_ADDR(FL_ADDR), .FL_DQ(FL_DQ),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_O(SRAM_DQ_O), .SRAM_DQ_I(SRAM_DQ_I),
    .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_WE_N(SRAM_WE_N), .SRAM_OE_N(SRAM_OE_N),
    .screen_sel(screen_sel), .page_lock(page_lock)
  );

  // Flash contents: a fixed pattern of the flash byte address
  function automatic logic [7:0] flash_byte(input int fa);
    logic [7:0] v;
    v = 8'(fa) ^ 8'((fa >> 8) & 63);
    if (((fa >> 14) & 1) != 0) v = v ^ 8'hA5;
    return v;
  endfunction
  assign FL_DQ = fl_force ? fl_force_val : flash_byte(int'(FL_ADDR));

  // Asynchronous-style SRAM: writes while WE_N low with data driven
  always @(posedge clk_mem) if (!SRAM_WE_N && SRAM_DQ_OE) sram[SRAM_ADDR] <= SRAM_DQ_O[7:0];
  assign SRAM_DQ_I = {8'h00, sram[SRAM_ADDR]};

  // Reference memory map
  function automatic int exp_sram(input logic [15:0] a);
    int bank;
    case (a[15:14])
      2'b01:   bank = 5;
      2'b10:   bank = 2;
      default: bank = int'(ref_page[2:0]);
    endcase
    return (bank % NRP) * 16384 + int'(a[13:0]);
  endfunction

  function automatic int exp_fl(input logic [15:0] a);
    int rom;
    rom = (RP > 1) ? int'(ref_page[4]) : 0;
    return rom * 16384 + int'(a[13:0]);
  endfunction

  function automatic void ref_io_write(input logic [15:0] a, input logic [7:0] d);
    if (!a[15] && !a[1] && !ref_page[5]) ref_page = d[5:0];
  endfunction

  task automatic cyc();
    @(posedge clk_mem); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    cyc(); cyc();
    reset = 1'b0; ref_page = '0;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d0, input logic [7:0] d1);
    A = a; D_in = d0; nIORQ = 1'b0; nWR = 1'b0;
    cyc(); D_in = d1; cyc(); cyc();
    nIORQ = 1'b1; nWR = 1'b1; cyc();
  endtask

  task automatic io_read(input logic [15:0] a, output logic doe, output logic [7:0] dout);
    A = a; nIORQ = 1'b0; nRD = 1'b0;
    #2; doe = d_oe; dout = D_out;
    cyc(); nIORQ = 1'b1; nRD = 1'b1; cyc();
  endtask

  // Bounded memory cycle driver; returns what was observed on the pins
  task automatic mem_op(input logic [15:0] a, input logic wr, input logic [7:0] wd,
                        output logic [7:0] rd, output int lat, output int nwl, output int wel,
                        output logic [AW-1:0] sa, output logic edoe);
    int k;
    logic done, fl;
    fl = (a[15:14] == 2'b00);
    A = a; D_in = wd; nMREQ = 1'b0; nRD = wr; nWR = !wr;
    rd = '0; lat = -1; nwl = 0; wel = 0; sa = '0; done = 1'b0; k = 0;
    while (!done && k < 20) begin
      cyc();
      if (k == 0) sa = SRAM_ADDR;
      if (!nWAIT) nwl++;
      if (!SRAM_WE_N) wel++;
      if (!wr && d_oe && lat < 0) begin lat = k; rd = D_out; end
      if (fl || !wr) done = (lat >= 0) || (fl && wr);
      else done = (wel > 0) && SRAM_WE_N;
      k++;
    end
    nMREQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    cyc();
    edoe = d_oe;
  endtask

  task automatic test_reset();
    logic [14:0] v;
    do_reset();
    v = {nWAIT, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE, d_oe, D_out, screen_sel, page_lock};
    n_tests++;
    if (v !== 15'b110_0000_0000_0000) begin n_fail++; $display("FAIL reset_state: got %b expected %b", v, 15'b110_0000_0000_0000); end
  endtask

  task automatic test_flash_read();
    logic [7:0] rd; int lat, nwl, wel; logic [AW-1:0] sa; logic edoe;
    fl_force = 1'b1; fl_force_val = 8'hF3;
    mem_op(16'h0000, 1'b0, 8'h00, rd, lat, nwl, wel, sa, edoe);
    n_tests++; if (rd !== 8'hF3) begin n_fail++; $display("FAIL flash_data: got %h expected f3", rd); end
    n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL flash_latency: got %0d expected 0", lat); end
    n_tests++; if (nwl !== 0) begin n_fail++; $display("FAIL flash_nwait: got %0d low cycles expected 0", nwl); end
    n_tests++; if (FL_ADDR !== 22'h0) begin n_fail++; $display("FAIL flash_addr: got %h expected 0", FL_ADDR); end
    n_tests++; if (edoe !== 1'b0) begin n_fail++; $display("FAIL flash_doe_release: got %b expected 0", edoe); end
    fl_force = 1'b0;
  endtask

  task automatic test_page_write();
    logic [7:0] rd; int lat, nwl, wel; logic [AW-1:0] sa; logic edoe;
    io_write(16'h7FFD, 8'h13, 8'h13); ref_io_write(16'h7FFD, 8'h13);
    n_tests++; if ({screen_sel, page_lock} !== 2'b00) begin n_fail++; $display("FAIL page13_flags: got %b expected 00", {screen_sel, page_lock}); end
    n_tests++; if (FL_ADDR[14] !== 1'b1) begin n_fail++; $display("FAIL page13_rom: got %b expected 1", FL_ADDR[14]); end
    mem_op(16'hC000, 1'b1, 8'hA5, rd, lat, nwl, wel, sa, edoe);
    ref_mem[32'h0C000] = 8'hA5;
    n_tests++; if (sa !== 18'h0C000) begin n_fail++; $display("FAIL page3_addr: got %h expected 0c000", sa); end
    n_tests++; if (wel !== WS + 1) begin n_fail++; $display("FAIL we_width: got %0d expected %0d", wel, WS + 1); end
    n_tests++; if (nwl !== WS) begin n_fail++; $display("FAIL nwait_width: got %0d expected %0d", nwl, WS); end
    n_tests++; if (SRAM_DQ_O !== 16'h00A5) begin n_fail++; $display("FAIL write_data: got %h expected 00a5", SRAM_DQ_O); end
    mem_op(16'h0123, 1'b0, 8'h00, rd, lat, nwl, wel, sa, edoe);
    n_tests++; if (rd !== flash_byte(exp_fl(16'h0123))) begin n_fail++; $display("FAIL rom1_data: got %h expected %h", rd, flash_byte(exp_fl(16'h0123))); end
  endtask

  task automatic test_fixed_banks();
    logic [7:0] rd; int lat, nwl, wel; logic [AW-1:0] sa; logic edoe;
    mem_op(16'h4000, 1'b1, 8'h55, rd, lat, nwl, wel, sa, edoe); ref_mem[32'h14000] = 8'h55;
    n_tests++; if (sa !== 18'h14000) begin n_fail++; $display("FAIL bank5_addr: got %h expected 14000", sa); end
    mem_op(16'h8000, 1'b1, 8'hAA, rd, lat, nwl, wel, sa, edoe); ref_mem[32'h08000] = 8'hAA;
    n_tests++; if (sa !== 18'h08000) begin n_fail++; $display("FAIL bank2_addr: got %h expected 08000", sa); end
    mem_op(16'h4000, 1'b0, 8'h00, rd, lat, nwl, wel, sa, edoe);
    n_tests++; if (rd !== 8'h55) begin n_fail++; $display("FAIL bank5_read: got %h expected 55", rd); end
    n_tests++; if (lat !== WS + 1) begin n_fail++; $display("FAIL read_latency: got %0d expected %0d", lat, WS + 1); end
    mem_op(16'h8000, 1'b0, 8'h00, rd, lat, nwl, wel, sa, edoe);
    n_tests++; if (rd !== 8'hAA) begin n_fail++; $display("FAIL bank2_read: got %h expected aa", rd); end
    mem_op(16'hC000, 1'b0, 8'h00, rd, lat, nwl, wel, sa, edoe);
    n_tests++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL bank3_read: got %h expected a5", rd); end
  endtask

  task automatic test_lock();
    logic [7:0] rd; int lat, nwl, wel; logic [AW-1:0] sa; logic edoe, doe; logic [7:0] dout;
    do_reset();
    io_write(16'h7FFD, 8'h20, 8'h20); ref_io_write(16'h7FFD, 8'h20);
    n_tests++; if (page_lock !== 1'b1) begin n_fail++; $display("FAIL lock_set: got %b expected 1", page_lock); end
    io_write(16'h7FFD, 8'h0F, 8'h0F); ref_io_write(16'h7FFD, 8'h0F);
    n_tests++; if (screen_sel !== ref_page[3]) begin n_fail++; $display("FAIL lock_screen: got %b expected %b", screen_sel, ref_page[3]); end
    mem_op(16'hC001, 1'b1, 8'h11, rd, lat, nwl, wel, sa, edoe); ref_mem[exp_sram(16'hC001)] = 8'h11;
    n_tests++; if (sa !== 18'(exp_sram(16'hC001))) begin n_fail++; $display("FAIL lock_bank: got %h expected %h", sa, 18'(exp_sram(16'hC001))); end
`ifdef ZX_PAGE_READBACK_EN
    io_read(16'h7FFD, doe, dout);
    n_tests++; if ({doe, dout} !== {1'b1, 2'b00, ref_page}) begin n_fail++; $display("FAIL lock_readback: got %b/%h expected 1/%h", doe, dout, {2'b00, ref_page}); end
`endif
    do_reset();
    n_tests++; if ({page_lock, screen_sel} !== 2'b00) begin n_fail++; $display("FAIL lock_cleared: got %b expected 00", {page_lock, screen_sel}); end
    io_read(16'h7FFD, doe, dout);
`ifdef ZX_PAGE_READBACK_EN
    n_tests++; if ({doe, dout} !== 9'h100) begin n_fail++; $display("FAIL reset_readback: got %b/%h expected 1/00", doe, dout); end
`else
    n_tests++; if (doe !== 1'b0) begin n_fail++; $display("FAIL no_readback: got d_oe=%b expected 0", doe); end
`endif
  endtask

  task automatic test_first_edge();
    logic [7:0] rd; int lat, nwl, wel; logic [AW-1:0] sa; logic edoe;
    io_write(16'h7FFD, 8'h08, 8'h17); ref_io_write(16'h7FFD, 8'h08);
    io_write(16'h7FFF, 8'h07, 8'h07); ref_io_write(16'h7FFF, 8'h07);
    io_write(16'hFFFD, 8'h06, 8'h06); ref_io_write(16'hFFFD, 8'h06);
    n_tests++; if (screen_sel !== 1'b1) begin n_fail++; $display("FAIL first_edge_screen: got %b expected 1", screen_sel); end
    mem_op(16'hC002, 1'b1, 8'h22, rd, lat, nwl, wel, sa, edoe); ref_mem[exp_sram(16'hC002)] = 8'h22;
    n_tests++; if (sa !== 18'(exp_sram(16'hC002))) begin n_fail++; $display("FAIL decode_bank: got %h expected %h", sa, 18'(exp_sram(16'hC002))); end
  endtask

  task automatic test_readback();
    logic doe; logic [7:0] dout;
    io_write(16'h7FFD, 8'h0F, 8'h0F); ref_io_write(16'h7FFD, 8'h0F);
    io_read(16'h7FFD, doe, dout);
`ifdef ZX_PAGE_READBACK_EN
    n_tests++; if ({doe, dout} !== 9'h10F) begin n_fail++; $display("FAIL readback: got %b/%h expected 1/0f", doe, dout); end
`else
    n_tests++; if (doe !== 1'b0) begin n_fail++; $display("FAIL readback_off: got d_oe=%b expected 0", doe); end
`endif
  endtask

  task automatic test_refresh();
    logic bad;
    bad = 1'b0;
    A = 16'h4321; nMREQ = 1'b0; nRD = 1'b1; nWR = 1'b1;
    repeat (4) begin
      cyc();
      bad = bad | !nWAIT | !SRAM_WE_N | d_oe | SRAM_DQ_OE;
    end
    nMREQ = 1'b1; cyc();
    n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL refresh_ignored: got activity=%b expected 0", bad); end
  endtask

  task automatic test_abort();
    logic [7:0] rd; int lat, nwl, wel; logic [AW-1:0] sa; logic edoe;
    A = 16'h8000; nMREQ = 1'b0; nRD = 1'b0;
    cyc(); cyc();
    n_tests++; if (nWAIT !== 1'b0) begin n_fail++; $display("FAIL abort_rd_pre: got nWAIT=%b expected 0", nWAIT); end
    nMREQ = 1'b1; nRD = 1'b1; cyc();
    n_tests++; if ({nWAIT, SRAM_WE_N, d_oe} !== 3'b110) begin n_fail++; $display("FAIL abort_rd: got %b expected 110", {nWAIT, SRAM_WE_N, d_oe}); end
    A = 16'h8004; D_in = 8'h3C; nMREQ = 1'b0; nWR = 1'b0;
    cyc(); cyc();
    n_tests++; if (SRAM_WE_N !== 1'b0) begin n_fail++; $display("FAIL abort_wr_pre: got WE_N=%b expected 0", SRAM_WE_N); end
    nMREQ = 1'b1; nWR = 1'b1; cyc();
    n_tests++; if ({nWAIT, SRAM_WE_N, d_oe} !== 3'b110) begin n_fail++; $display("FAIL abort_wr: got %b expected 110", {nWAIT, SRAM_WE_N, d_oe}); end
    mem_op(16'h8004, 1'b1, 8'h3C, rd, lat, nwl, wel, sa, edoe); ref_mem[32'h08004] = 8'h3C;
    n_tests++; if (wel !== WS + 1) begin n_fail++; $display("FAIL after_abort_we: got %0d expected %0d", wel, WS + 1); end
  endtask

  task automatic test_reset_mid();
    logic [14:0] v;
    A = 16'hC010; D_in = 8'h99; nMREQ = 1'b0; nWR = 1'b0;
    cyc();
    reset = 1'b1; cyc();
    v = {nWAIT, SRAM_WE_N, SRAM_OE_N, SRAM_DQ_OE, d_oe, D_out, screen_sel, page_lock};
    reset = 1'b0; nMREQ = 1'b1; nWR = 1'b1; ref_page = '0;
    cyc();
    n_tests++; if (v !== 15'b110_0000_0000_0000) begin n_fail++; $display("FAIL reset_mid: got %b expected %b", v, 15'b110_0000_0000_0000); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; int lat, nwl, wel; logic [AW-1:0] sa; logic edoe;
    mem_op(16'h4100, 1'b1, 8'h6B, rd, lat, nwl, wel, sa, edoe); ref_mem[32'h14100] = 8'h6B;
    mem_op(16'h4100, 1'b0, 8'h00, rd, lat, nwl, wel, sa, edoe);
    n_tests++; if (rd !== 8'h6B) begin n_fail++; $display("FAIL back_to_back: got %h expected 6b", rd); end
  endtask

  task automatic test_random();
    logic [15:0] a; logic [7:0] d, rd; int lat, nwl, wel, kind, se; logic [AW-1:0] sa; logic edoe;
    for (int i = 0; i < 120; i++) begin
      kind = int'($urandom_range(0, 99));
      if (kind < 15) begin
        case ($urandom_range(0, 3))
          0:       a = 16'h7FFD;
          1:       a = 16'h3FFD;
          2:       a = 16'hFFFD;
          default: a = 16'h00FE;
        endcase
        d = 8'($urandom) & 8'hDF;
        io_write(a, d, d); ref_io_write(a, d);
        n_tests++; if ({screen_sel, page_lock} !== {ref_page[3], ref_page[5]}) begin n_fail++; $display("FAIL rnd_page %0d: got %b expected %b", i, {screen_sel, page_lock}, {ref_page[3], ref_page[5]}); end
      end else if (kind < 55) begin
        a = 16'($urandom);
        if (a[15:14] == 2'b00) a[15:14] = 2'($urandom_range(1, 3));
        d = 8'($urandom);
        mem_op(a, 1'b1, d, rd, lat, nwl, wel, sa, edoe);
        se = exp_sram(a); ref_mem[se] = d; wq.push_back(a);
        n_tests++; if (sa !== 18'(se) || wel !== WS + 1) begin n_fail++; $display("FAIL rnd_write %0d: got addr %h we %0d expected %h we %0d", i, sa, wel, 18'(se), WS + 1); end
      end else begin
        if (wq.size() > 0 && $urandom_range(0, 1) == 1) a = wq[$urandom_range(0, wq.size() - 1)];
        else a = 16'($urandom);
        mem_op(a, 1'b0, 8'h00, rd, lat, nwl, wel, sa, edoe);
        if (a[15:14] == 2'b00) begin
          n_tests++; if (rd !== flash_byte(exp_fl(a)) || lat !== 0) begin n_fail++; $display("FAIL rnd_flash %0d: got %h lat %0d expected %h lat 0", i, rd, lat, flash_byte(exp_fl(a))); end
        end else begin
          se = exp_sram(a);
          n_tests++; if (sa !== 18'(se) || lat !== WS + 1) begin n_fail++; $display("FAIL rnd_read %0d: got addr %h lat %0d expected %h lat %0d", i, sa, lat, 18'(se), WS + 1); end
          if (ref_mem.exists(se)) begin
            n_tests++; if (rd !== ref_mem[se]) begin n_fail++; $display("FAIL rnd_data %0d: got %h expected %h", i, rd, ref_mem[se]); end
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; A = '0; D_in = '0; nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    fl_force = 1'b0; fl_force_val = '0; ref_page = '0;
    test_reset();
    test_flash_read();
    test_page_write();
    test_fixed_banks();
    test_lock();
    test_first_edge();
    test_readback();
    test_refresh();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
